icon_effect_selector: RTL and testbench

- Parametrised successor to the fixed 8-icon effect picker: randomly rolls an effect index while idle, freezes it on a button press, arms after a debounce, then runs the effect for a timed window followed by a cooldown.
- Draws a ROWS x COLS grid of ICON_W x ICON_H icons from one shared icon ROM (single address bus plus icon index) into the VGA pixel stream.
- Sits between the VGA timing generator/icon ROM and the video-effects mux.

---
 rtl/icon_effect_selector_if.sv | 32 +++
 rtl/icon_effect_selector.sv | 198 +++++++++++++++++++
 tb/tb_icon_effect_selector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/icon_effect_selector_if.sv
// Bundles the button, video-position and icon-ROM signals of icon_effect_selector.
// The master side drives the button, cancel and pixel position and returns ROM data.
interface icon_effect_selector_if #(
  parameter int unsigned N_ICONS = 8,
  parameter int unsigned ICON_W  = 32,
  parameter int unsigned ICON_H  = 32
);
  localparam int unsigned AW = $clog2(ICON_W * ICON_H);
  localparam int unsigned IW = $clog2(N_ICONS);

  logic          button;
  logic          cancel;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [23:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_icon;
  logic [IW-1:0] effect;
  logic          effect_en;
  logic          busy;
  logic [29:0]   pixel;

  modport master (
    output button, cancel, x, y, rom_data,
    input  rom_addr, rom_icon, effect, effect_en, busy, pixel
  );

  modport slave (
    input  button, cancel, x, y, rom_data,
    output rom_addr, rom_icon, effect, effect_en, busy, pixel
  );
endinterface

// File: rtl/icon_effect_selector.sv
// Random effect picker with debounce/run/cooldown sequencing, plus a two-stage
// overlay that draws the icon grid from a shared icon ROM into the pixel stream.
module icon_effect_selector #(
  parameter int unsigned N_ICONS         = 8,
  parameter int unsigned ROWS            = 2,
  parameter int unsigned COLS            = 4,
  parameter int unsigned ICON_W          = 32,
  parameter int unsigned ICON_H          = 32,
  parameter int unsigned ORIGIN_X        = 150,
  parameter int unsigned ORIGIN_Y        = 300,
  parameter int unsigned PITCH_X         = 100,
  parameter int unsigned PITCH_Y         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 4194304,
  parameter int unsigned RUN_CYCLES      = 270000000,
  parameter int unsigned COOL_CYCLES     = 270000000,
  parameter int unsigned DIM_OTHERS      = 0
) (
  input logic                   clk,
  input logic                   reset,
  icon_effect_selector_if.slave bus
);
  localparam int unsigned AW      = $clog2(ICON_W * ICON_H);
  localparam int unsigned IW      = $clog2(N_ICONS);
  localparam int unsigned MAX_RC  = (RUN_CYCLES > COOL_CYCLES) ? RUN_CYCLES : COOL_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_RC > DEBOUNCE_CYCLES) ? MAX_RC : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    CHOOSING = 3'd0,
    DEBOUNCE = 3'd1,
    READY    = 3'd2,
    RUNNING  = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] effect_q, effect_n;
  logic          en_q, en_n;
  logic          busy_q, busy_n;
  logic [15:0]   lfsr;
  logic [IW-1:0] roll;
  logic          frame_end;

  assign frame_end = (bus.x == 10'd639) && (bus.y == 10'd479);
  assign roll      = IW'(({8'd0, lfsr[7:0]} * 16'(N_ICONS)) >> 8);

  // Fibonacci LFSR, taps 16,14,13,11; one step per frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else if (frame_end) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CHOOSING;
      cnt      <= '0;
      effect_q <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      effect_q <= effect_n;
      en_q     <= en_n;
      busy_q   <= busy_n;
    end
  end

  // One counter serves as debounce counter, run timer and cooldown timer
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    effect_n = effect_q;
    en_n     = en_q;
    case (state)
      CHOOSING: begin
        if (bus.button) begin
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end else begin
          effect_n = roll;
        end
      end
      DEBOUNCE: begin
        if (bus.button) begin
          cnt_n = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = READY;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      READY: begin
        if (bus.button) begin
          en_n    = 1'b1;
          cnt_n   = '0;
          state_n = RUNNING;
        end
      end
      RUNNING: begin
        if (bus.cancel || (cnt == CW'(RUN_CYCLES - 1))) begin
          en_n     = 1'b0;
          effect_n = '0;
          cnt_n    = '0;
          state_n  = COOLDOWN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      COOLDOWN: begin
        if (cnt == CW'(COOL_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = CHOOSING;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n  = CHOOSING;
        cnt_n    = '0;
        effect_n = '0;
        en_n     = 1'b0;
      end
    endcase
    busy_n = (state_n == RUNNING) || (state_n == COOLDOWN);
  end

  // Stage 1: grid cell lookup straight from x,y
  logic          hit_c;
  logic [IW-1:0] idx_c;
  logic [AW-1:0] addr_c;

  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    addr_c = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((r * COLS + c < N_ICONS) &&
            (32'(bus.x) >= ORIGIN_X + c * PITCH_X) &&
            (32'(bus.x) <  ORIGIN_X + c * PITCH_X + ICON_W) &&
            (32'(bus.y) >= ORIGIN_Y + r * PITCH_Y) &&
            (32'(bus.y) <  ORIGIN_Y + r * PITCH_Y + ICON_H)) begin
          hit_c  = 1'b1;
          idx_c  = IW'(r * COLS + c);
          addr_c = AW'((32'(bus.y) - (ORIGIN_Y + r * PITCH_Y)) * ICON_W +
                       (32'(bus.x) - (ORIGIN_X + c * PITCH_X)));
        end
      end
    end
  end

  // Stage 2: colour expansion; a quarter of {c,c[1:0]} is simply c zero-extended
  logic [29:0] bright_c, dim_c, pix_c;
  logic [AW-1:0] rom_addr_q;
  logic [IW-1:0] rom_icon_q;
  logic          hit_q;
  logic [29:0]   pixel_q;

  assign bright_c = {bus.rom_data[23:16], bus.rom_data[17:16],
                     bus.rom_data[15:8],  bus.rom_data[9:8],
                     bus.rom_data[7:0],   bus.rom_data[1:0]};
  assign dim_c    = {2'b00, bus.rom_data[23:16], 2'b00, bus.rom_data[15:8],
                     2'b00, bus.rom_data[7:0]};

  always_comb begin
    pix_c = '0;
    if (hit_q && !busy_q) begin
      if (rom_icon_q == effect_q) pix_c = bright_c;
      else if (DIM_OTHERS != 0)   pix_c = dim_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_q <= '0;
      rom_icon_q <= '0;
      hit_q      <= 1'b0;
      pixel_q    <= '0;
    end else begin
      hit_q   <= hit_c;
      pixel_q <= pix_c;
      if (hit_c) begin
        rom_addr_q <= addr_c;
        rom_icon_q <= idx_c;
      end
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_icon  = rom_icon_q;
  assign bus.effect    = effect_q;
  assign bus.effect_en = en_q;
  assign bus.busy      = busy_q;
  assign bus.pixel     = pixel_q;
endmodule

// File: tb/tb_icon_effect_selector.sv
// Directed bench for icon_effect_selector: two instances (plain and dimmed
// others) share one stimulus; video vectors are table driven.
`timescale 1ns/1ps
module tb_icon_effect_selector;
  logic        clk = 1'b0;
  logic        reset;
  logic        button, cancel;
  logic [9:0]  x, y;
  logic [23:0] rom_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icon_effect_selector_if #(.N_ICONS(8), .ICON_W(32), .ICON_H(32)) if0 ();
  icon_effect_selector_if #(.N_ICONS(8), .ICON_W(32), .ICON_H(32)) if1 ();

  assign if0.button = button;   assign if1.button = button;
  assign if0.cancel = cancel;   assign if1.cancel = cancel;
  assign if0.x = x;             assign if1.x = x;
  assign if0.y = y;             assign if1.y = y;
  assign if0.rom_data = rom_data; assign if1.rom_data = rom_data;

  icon_effect_selector #(.DEBOUNCE_CYCLES(16), .RUN_CYCLES(100), .COOL_CYCLES(50),
                         .DIM_OTHERS(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  icon_effect_selector #(.DEBOUNCE_CYCLES(16), .RUN_CYCLES(100), .COOL_CYCLES(50),
                         .DIM_OTHERS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    logic [9:0]  vx;
    logic [9:0]  vy;
    logic [23:0] data;
    logic        chk_rom;
    logic [2:0]  icon;
    logic [9:0]  addr;
    logic [29:0] pix0;
    logic [29:0] pix1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_end();
    x = 10'd639; y = 10'd479;
    step(1);
    x = 10'd0; y = 10'd0;
  endtask

  // CHOOSING -> DEBOUNCE -> READY -> RUNNING with a clean 16-cycle release
  task automatic start_run();
    button = 1'b1; step(1);
    button = 1'b0; step(16);
    button = 1'b1; step(1);
    button = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_en, n_busy;
    logic prev_en;

    vecs[0]  = '{10'd253, 10'd305, 24'hFF8001, 1'b1, 3'd1, 10'd163,  30'h3FF80005, 30'h3FF80005};
    vecs[1]  = '{10'd153, 10'd305, 24'hFF8001, 1'b1, 3'd0, 10'd163,  30'h0,        30'h0FF20001};
    vecs[2]  = '{10'd150, 10'd300, 24'h123456, 1'b1, 3'd0, 10'd0,    30'h0,        30'h0120D056};
    vecs[3]  = '{10'd281, 10'd331, 24'hAABBCC, 1'b1, 3'd1, 10'd1023, 30'h2AABBF30, 30'h2AABBF30};
    vecs[4]  = '{10'd282, 10'd300, 24'hFFFFFF, 1'b0, 3'd0, 10'd0,    30'h0,        30'h0};
    vecs[5]  = '{10'd250, 10'd332, 24'hFFFFFF, 1'b0, 3'd0, 10'd0,    30'h0,        30'h0};
    vecs[6]  = '{10'd453, 10'd405, 24'h808080, 1'b1, 3'd7, 10'd163,  30'h0,        30'h08020080};
    vecs[7]  = '{10'd350, 10'd400, 24'hFFFFFF, 1'b1, 3'd6, 10'd0,    30'h0,        30'h0FF3FCFF};
    vecs[8]  = '{10'd149, 10'd300, 24'hFFFFFF, 1'b0, 3'd0, 10'd0,    30'h0,        30'h0};
    vecs[9]  = '{10'd249, 10'd331, 24'hFFFFFF, 1'b0, 3'd0, 10'd0,    30'h0,        30'h0};
    vecs[10] = '{10'd181, 10'd331, 24'h010203, 1'b1, 3'd0, 10'd1023, 30'h0,        30'h00100803};

    reset = 1'b0; button = 1'b0; cancel = 1'b0;
    x = 10'd0; y = 10'd0; rom_data = 24'd0;
    step(3);
    check("reset_effect",    32'(if0.effect),    32'd0);
    check("reset_effect_en", 32'(if0.effect_en), 32'd0);
    check("reset_busy",      32'(if0.busy),      32'd0);
    check("reset_pixel",     32'(if0.pixel),     32'd0);
    check("reset_rom_addr",  32'(if0.rom_addr),  32'd0);
    check("reset_rom_icon",  32'(if0.rom_icon),  32'd0);

    // Rolls from seed ACE1: 7, then 3, 1, 4, 6 after successive frame ends
    reset = 1'b1;
    step(1);
    check("roll_seed",       32'(if0.effect),    32'd7);
    check("roll_seed_dim",   32'(if1.effect),    32'd7);
    check("idle_effect_en",  32'(if0.effect_en), 32'd0);
    check("idle_busy",       32'(if0.busy),      32'd0);
    frame_end(); step(1);
    check("roll_frame1", 32'(if0.effect), 32'd3);
    frame_end(); step(1);
    check("roll_frame2", 32'(if0.effect), 32'd1);

    for (int i = 0; i < 11; i++) begin
      x = vecs[i].vx; y = vecs[i].vy; rom_data = vecs[i].data;
      step(1);
      if (vecs[i].chk_rom) begin
        check($sformatf("vec%0d_rom_icon", i), 32'(if0.rom_icon), 32'(vecs[i].icon));
        check($sformatf("vec%0d_rom_addr", i), 32'(if0.rom_addr), 32'(vecs[i].addr));
      end
      step(1);
      check($sformatf("vec%0d_pixel", i),     32'(if0.pixel), 32'(vecs[i].pix0));
      check($sformatf("vec%0d_pixel_dim", i), 32'(if1.pixel), 32'(vecs[i].pix1));
    end

    // Pixel must lag x,y by exactly two cycles
    x = 10'd253; y = 10'd305; rom_data = 24'h000000;
    step(1);
    x = 10'd149; y = 10'd300; rom_data = 24'hFF8001;
    step(1);
    check("latency_hit", 32'(if0.pixel), 32'h3FF80005);
    rom_data = 24'h000000;
    step(1);
    check("latency_miss", 32'(if0.pixel), 32'd0);
    x = 10'd0; y = 10'd0;

    frame_end(); step(1);
    check("roll_frame3", 32'(if0.effect), 32'd4);

    // Debounce: 10 releases (with a frame end), press, 15 releases, press, 16 releases
    button = 1'b1; step(1);
    button = 1'b0;
    check("frozen_after_press", 32'(if0.effect), 32'd4);
    step(9);
    frame_end();
    check("frozen_over_frame", 32'(if0.effect), 32'd4);
    button = 1'b1; step(1);
    button = 1'b0; step(15);
    button = 1'b1; step(1);
    button = 1'b0;
    check("no_start_after_15", 32'(if0.effect_en), 32'd0);
    check("no_busy_after_15",  32'(if0.busy),      32'd0);
    step(16);
    check("ready_effect_en", 32'(if0.effect_en), 32'd0);
    check("ready_effect",    32'(if0.effect),    32'd4);
    cancel = 1'b1; step(1);
    cancel = 1'b0; step(3);
    check("cancel_in_ready", 32'(if0.effect_en), 32'd0);

    // Full run: 100 cycles enabled, 150 busy, overlay blanked throughout
    button = 1'b1; step(1);
    button = 1'b0;
    check("run_effect_en", 32'(if0.effect_en), 32'd1);
    check("run_busy",      32'(if0.busy),      32'd1);
    check("run_effect",    32'(if0.effect),    32'd4);
    x = 10'd153; y = 10'd405; rom_data = 24'hFFFFFF;
    n_en = 1; n_busy = 1; prev_en = 1'b1;
    for (int k = 0; k < 300 && if0.busy; k++) begin
      step(1);
      if (k == 5) begin
        check("busy_pixel",     32'(if0.pixel), 32'd0);
        check("busy_pixel_dim", 32'(if1.pixel), 32'd0);
      end
      if (prev_en && !if0.effect_en)
        check("effect_cleared", 32'(if0.effect), 32'd0);
      prev_en = if0.effect_en;
      if (if0.effect_en) n_en++;
      if (if0.busy) n_busy++;
    end
    x = 10'd0; y = 10'd0;
    check("run_en_cycles",   32'(n_en),   32'd100);
    check("run_busy_cycles", 32'(n_busy), 32'd150);
    check("back_effect_zero", 32'(if0.effect), 32'd0);
    step(1);
    check("back_roll", 32'(if0.effect), 32'd6);

    // Cancel at run cycle 20; cooldown still lasts 50 cycles
    start_run();
    check("cancel_run_en", 32'(if0.effect_en), 32'd1);
    step(19);
    check("en_before_cancel", 32'(if0.effect_en), 32'd1);
    cancel = 1'b1; step(1);
    cancel = 1'b0;
    check("en_after_cancel",     32'(if0.effect_en), 32'd0);
    check("effect_after_cancel", 32'(if0.effect),    32'd0);
    n_busy = 0;
    for (int k = 0; k < 200 && if0.busy; k++) begin
      n_busy++;
      step(1);
    end
    check("cooldown_cycles", 32'(n_busy), 32'd50);

    // Asynchronous reset in the middle of a run
    start_run();
    step(5);
    check("pre_reset_en", 32'(if0.effect_en), 32'd1);
    reset = 1'b0;
    #1;
    check("async_effect",    32'(if0.effect),    32'd0);
    check("async_effect_en", 32'(if0.effect_en), 32'd0);
    check("async_busy",      32'(if0.busy),      32'd0);
    check("async_pixel",     32'(if0.pixel),     32'd0);
    check("async_rom_addr",  32'(if0.rom_addr),  32'd0);
    check("async_rom_icon",  32'(if0.rom_icon),  32'd0);
    check("async_busy_dim",  32'(if1.busy),      32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    check("reseed_roll", 32'(if0.effect), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
